// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers and parameter legality checks for sync_fifo
package sync_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int afull, input int aempty);
    return (width >= 1) && is_pow2(depth) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - WIDTHxDEPTH storage, one write port, one registered read port
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-before-write: a same-address write this cycle is not visible until next read.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, threshold flags and push-through when full
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         pop,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_out_valid,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ptr_w(DEPTH);
  localparam logic [CW-1:0] AF_T  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_T  = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  localparam logic          AF_RST = (AFULL_THRESH == 0);

  if (!params_ok(WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("sync_fifo: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [CW-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic          r_full, r_empty, r_afull, r_aempty, r_dout_valid;
  logic          w_push_ok, w_pop_ok;
  logic [CW-1:0] w_count_nxt;

  // A push into a full FIFO is only legal when the oldest word leaves in the same cycle.
  assign w_push_ok   = push & (~r_full | pop);
  assign w_pop_ok    = pop & ~r_empty;
  assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= AF_RST;
      r_aempty     <= 1'b1;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + CW'(1);
      r_count      <= w_count_nxt;
      r_full       <= (w_count_nxt == FULLC);
      r_empty      <= (w_count_nxt == '0);
      r_afull      <= (w_count_nxt >= AF_T);
      r_aempty     <= (w_count_nxt <= AE_T);
      r_dout_valid <= w_pop_ok;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (clk),
    .i_resetn  (reset_n),
    .i_wr_en   (w_push_ok),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (data_in),
    .i_rd_en   (w_pop_ok),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow, r_underflow;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (push & ~w_push_ok) | (r_overflow  & ~err_clr);
      r_underflow <= (pop & r_empty)     | (r_underflow & ~err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign data_out_valid = r_dout_valid;
  assign count          = r_count;
  assign full           = r_full;
  assign empty          = r_empty;
  assign almost_full    = r_afull;
  assign almost_empty   = r_aempty;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo (WIDTH=8, DEPTH=16)
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, push, pop, err_clr;
  logic [7:0] data_in, data_out;
  logic       data_out_valid, full, empty, almost_full, almost_empty;
  logic       overflow, underflow;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       exp_v;

  sync_fifo dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .push           (push),
    .data_in        (data_in),
    .pop            (pop),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .err_clr        (err_clr),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
    tick(); tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    reset_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; data_in = 8'(i);
      tick();
      chk("fill_count", count, i);
      chk("fill_full", full, (i == 16));
      chk("fill_afull", almost_full, (i >= 14));
      chk("fill_aempty", almost_empty, (i <= 2));
      chk("fill_empty", empty, 0);
    end
    push = 1'b0;

    for (int i = 1; i <= 16; i++) begin
      pop = 1'b1;
      tick();
      chk("drain_data", data_out, i);
      chk("drain_valid", data_out_valid, 1);
      chk("drain_count", count, 16 - i);
      chk("drain_empty", empty, (i == 16));
      chk("drain_aempty", almost_empty, (16 - i <= 2));
    end
    pop = 1'b0;
    tick();
    chk("idle_valid", data_out_valid, 0);
    chk("idle_hold", data_out, 8'h10);

    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; data_in = 8'(i);
      tick();
    end
    chk("refill_full", full, 1);
    pop = 1'b1; data_in = 8'hAA;
    tick();
    chk("pt_data", data_out, 8'h01);
    chk("pt_valid", data_out_valid, 1);
    chk("pt_count", count, 16);
    chk("pt_full", full, 1);
    push = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("pt_drain", data_out, (j == 15) ? 8'hAA : 8'(j + 2));
    end
    pop = 1'b0;
    tick();
    chk("pt_empty", empty, 1);

    for (int k = 0; k < 45; k++) begin
      push = (k < 40); pop = (k >= 5); data_in = 8'(8'h40 + k);
      exp_v = 1'b0; exp_d = '0;
      if (pop && q.size() > 0) begin
        exp_v = 1'b1;
        exp_d = q.pop_front();
      end
      if (push) q.push_back(data_in);
      tick();
      chk("wrap_valid", data_out_valid, exp_v);
      if (exp_v) chk("wrap_data", data_out, exp_d);
      chk("wrap_count", count, q.size());
    end
    push = 1'b0; pop = 1'b0;
    tick();
    chk("wrap_empty", empty, 1);

    pop = 1'b1;
    tick();
    chk("unf_valid", data_out_valid, 0);
    chk("unf_count", count, 0);
    chk("unf_flag", underflow, ERR);
    pop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; data_in = 8'(8'h80 + i);
      tick();
    end
    chk("unf_sticky", underflow, ERR);
    data_in = 8'hEE;
    tick();
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, ERR);
    err_clr = 1'b1;
    tick();
    chk("ovf_setwins", overflow, ERR);
    chk("unf_clr", underflow, 0);
    push = 1'b0;
    tick();
    chk("ovf_clr", overflow, 0);
    err_clr = 1'b0;

    for (int i = 0; i < 9; i++) begin
      pop = 1'b1;
      tick();
      chk("err_drain", data_out, 8'(8'h80 + i));
    end
    chk("pre_rst_count", count, 7);
    reset_n = 1'b0; push = 1'b1; pop = 1'b1; data_in = 8'h99;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_valid", data_out_valid, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_data", data_out, 0);
    reset_n = 1'b1; pop = 1'b0; data_in = 8'h55;
    tick();
    chk("post_rst_count", count, 1);
    chk("post_rst_empty", empty, 0);
    push = 1'b0; pop = 1'b1;
    tick();
    chk("post_rst_data", data_out, 8'h55);
    chk("post_rst_valid", data_out_valid, 1);
    chk("post_rst_cnt0", count, 0);
    pop = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the next generation of the team's basic push/pop FIFO. It adds configurable width and depth, a registered read port and an occupancy count. It also provides programmable almost-full/almost-empty flags, same-cycle push-through when full, and optional sticky overflow/underflow error flags. It sits between any producer and consumer in the same clock domain, for example UART/SPI byte buffering on the E310 peripheral bus.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- push  in  1  write request
- data_in  in  WIDTH  write data, sampled when a push is accepted
- pop  in  1  read request
- data_out  out  WIDTH  read data, registered
- data_out_valid  out  1  one-cycle pulse: data_out holds a popped word
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- err_clr  in  1  clears sticky error flags
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was made while empty

## Operation
- push_ok = push && (!full || pop). A push while full is accepted only if a pop is accepted in the same cycle.
- pop_ok = pop && !empty.
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. The memory index is ptr[$clog2(DEPTH)-1:0].
- Each pointer increments by 1 modulo 2·DEPTH when its operation is accepted; wrap from DEPTH-1 to 0 is natural.
- count next value is count + push_ok − pop_ok. count == wr_ptr − rd_ptr at all times.
- full, empty, almost_full and almost_empty are registered, derived from the next count, and valid in the same cycle as count.
- push and pop together when empty: only the push is accepted; count goes 0→1, no data_out_valid.
- push and pop together when full: both are accepted; count stays DEPTH and the oldest word is returned.
- push and pop together at any other occupancy: both are accepted and count is unchanged.
- Memory contents are not reset. Only words written since reset are ever read.
- Reset mid-operation: all pointers, count and flags return to their reset values on the next clock edge. Stored data is logically discarded. data_out_valid is forced low.

## Timing
- Reset values: data_out=0, data_out_valid=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0 ? 1 : 0) (i.e. 0 for legal values), overflow=0, underflow=0.
- Write-to-read: a word pushed in cycle N can be popped in cycle N+1; empty deasserts in cycle N+1.
- Read latency: pop_ok in cycle N gives data_out and data_out_valid=1 in cycle N+1. data_out holds its value until the next pop_ok.
- Back-to-back pops give one word per cycle with data_out_valid continuously high.

## Configuration
- SYNC_FIFO_ERR_EN defined:
  - overflow sets on push && !push_ok.
  - underflow sets on pop && empty.
  - Both flags stay set until err_clr=1 or reset. If err_clr and a new error occur in the same cycle, the flag stays set (set wins).
- SYNC_FIFO_ERR_EN undefined:
  - overflow and underflow are tied to 0 and err_clr is ignored.
  - Ports remain present so instantiations do not change.

## Structure
- Package sync_fifo_pkg holds:
  - the function ptr_w(depth) = $clog2(depth)+1;
  - elaboration-time parameter checks (DEPTH is a power of two; thresholds are in range).
- One sub-module, sync_fifo_mem:
  - WIDTH×DEPTH storage with one write port and one read port;
  - registered read data; inferable as distributed or block RAM.
- Pointers, count, flags and the error logic live in sync_fifo.

## Test plan
- Reset, then push 0x01..0x10 (WIDTH=8, DEPTH=16): full=1 after the 16th push. almost_full=1 once count reaches 14. count=16.
- From full, pop 16 times: data_out=0x01..0x10 in order, each one cycle after its pop. empty=1 after the last pop. almost_empty=1 once count reaches 2.
- Hold full, push 0xAA with pop asserted: data_out=0x01, count stays 16, and 0xAA is later read as the last word.
- Push 40 words and pop 40 words interleaved (pointer wrap twice): read order matches write order and count never exceeds 16.
- With SYNC_FIFO_ERR_EN: push while full without pop sets overflow=1, and count is unchanged. Pop while empty sets underflow=1 and gives no data_out_valid. err_clr clears both flags one cycle later.
- Assert reset_n=0 for one cycle at count=7: the next cycle shows count=0, empty=1 and data_out_valid=0. A subsequent push of 0x55 followed by a pop returns 0x55.
